// File: rtl/fb_muldiv_unit_pkg.sv
// Shared encodings for the Firebird RV32M/RV64M multiply/divide unit.
// The optional divide/remainder fusion is enabled by defining FB_MULDIV_REM_FUSE_EN.
package fb_muldiv_unit_pkg;

    localparam int MD_OP_MUL    = 7;
    localparam int MD_OP_MULH   = 6;
    localparam int MD_OP_MULHSU = 5;
    localparam int MD_OP_MULHU  = 4;
    localparam int MD_OP_DIV    = 3;
    localparam int MD_OP_DIVU   = 2;
    localparam int MD_OP_REM    = 1;
    localparam int MD_OP_REMU   = 0;

    typedef enum logic [2:0] {
        MD_ST_IDLE = 3'd0,
        MD_ST_MUL  = 3'd1,
        MD_ST_DIV  = 3'd2,
        MD_ST_FIX  = 3'd3,
        MD_ST_DONE = 3'd4
    } md_state_e;

    // Operation kind; the ordering mirrors op[7:0] MSB first.
    typedef enum logic [2:0] {
        MD_K_MUL    = 3'd0,
        MD_K_MULH   = 3'd1,
        MD_K_MULHSU = 3'd2,
        MD_K_MULHU  = 3'd3,
        MD_K_DIV    = 3'd4,
        MD_K_DIVU   = 3'd5,
        MD_K_REM    = 3'd6,
        MD_K_REMU   = 3'd7
    } md_kind_e;

    // Highest-order set bit wins; scanning upwards lets later hits override.
    function automatic md_kind_e md_decode(input logic [7:0] op);
        md_kind_e kind;
        kind = MD_K_MUL;
        for (int i = 0; i < 8; i++) begin
            if (op[i]) kind = md_kind_e'(3'(MD_OP_MUL - i));
        end
        return kind;
    endfunction

endpackage

// File: rtl/fb_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module fb_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;

    // rem_in < divisor, so the difference always fits back into XLEN bits.
    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];

endmodule

// File: rtl/fb_muldiv_unit.sv
// Multi-cycle M-extension execute unit: single-cycle registered multiply, iterative
// restoring divide with sign fix-up. Define FB_MULDIV_REM_FUSE_EN to reuse the last divide.
module fb_muldiv_unit
    import fb_muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_STEP = 1,
    parameter int CNT_W    = $clog2(XLEN / DIV_STEP) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [CNT_W-1:0] ITERS = CNT_W'(XLEN / DIV_STEP);

    md_state_e        state, state_nx;
    md_kind_e         kind_in, kind_q;
    logic             accept, is_mul_in, sgn_in, rem_in, special, fuse_hit;
    logic             rs1_neg, rs2_neg, div_zero, div_ovf;
    logic [XLEN-1:0]  special_res, fuse_res, quo_fix, rem_fix;
    logic [XLEN:0]    mul_a, mul_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, result_q;
    logic             neg_q, neg_r;
    logic [CNT_W-1:0] cnt;

    assign kind_in   = md_decode(op);
    assign is_mul_in = kind_in inside {MD_K_MUL, MD_K_MULH, MD_K_MULHSU, MD_K_MULHU};
    assign sgn_in    = kind_in inside {MD_K_DIV, MD_K_REM};
    assign rem_in    = kind_in inside {MD_K_REM, MD_K_REMU};
    assign accept    = in_valid && in_ready && (op != 8'd0) && !flush;

    assign rs1_neg  = sgn_in && rs1[XLEN-1];
    assign rs2_neg  = sgn_in && rs2[XLEN-1];
    assign div_zero = (rs2 == '0);
    assign div_ovf  = sgn_in && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign special  = div_zero || div_ovf;
    assign special_res = rem_in ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);

    assign prod = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};

    assign quo_fix = neg_q ? -quo_q : quo_q;
    assign rem_fix = neg_r ? -rem_q : rem_q;

    // Restoring divide chain, DIV_STEP dividend bits consumed per cycle from quo_q's MSBs.
    logic [XLEN-1:0]     chain_rem [DIV_STEP+1];
    logic [DIV_STEP-1:0] q_bits;

    assign chain_rem[0] = rem_q;
    for (genvar i = 0; i < DIV_STEP; i++) begin : g_step
        fb_div_step #(.XLEN(XLEN)) u_step (
            .rem_in  (chain_rem[i]),
            .bit_in  (quo_q[XLEN-1-i]),
            .divisor (dvsr_q),
            .rem_out (chain_rem[i+1]),
            .q_bit   (q_bits[DIV_STEP-1-i])
        );
    end

`ifdef FB_MULDIV_REM_FUSE_EN
    logic            fuse_vld, fuse_sgn;
    logic [XLEN-1:0] fuse_rs1, fuse_rs2, fuse_quo, fuse_rem;

    assign fuse_hit = fuse_vld && (fuse_sgn == sgn_in) && (fuse_rs1 == rs1) && (fuse_rs2 == rs2);
    assign fuse_res = rem_in ? fuse_rem : fuse_quo;

    // The key is captured at accept; the entry only becomes valid once FIX completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fuse_vld <= 1'b0;
            fuse_sgn <= 1'b0;
            fuse_rs1 <= '0;
            fuse_rs2 <= '0;
            fuse_quo <= '0;
            fuse_rem <= '0;
        end else if (flush) begin
            fuse_vld <= 1'b0;
        end else if (accept && is_mul_in) begin
            fuse_vld <= 1'b0;
        end else if (accept && !special && !fuse_hit) begin
            fuse_vld <= 1'b0;
            fuse_sgn <= sgn_in;
            fuse_rs1 <= rs1;
            fuse_rs2 <= rs2;
        end else if (state == MD_ST_FIX) begin
            fuse_vld <= 1'b1;
            fuse_quo <= quo_fix;
            fuse_rem <= rem_fix;
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_res = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_ST_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        in_ready  = (state == MD_ST_IDLE);
        busy      = (state != MD_ST_IDLE);
        out_valid = (state == MD_ST_DONE);
        case (state)
            MD_ST_IDLE: begin
                if (accept) begin
                    if (is_mul_in)                state_nx = MD_ST_MUL;
                    else if (special || fuse_hit) state_nx = MD_ST_DONE;
                    else                          state_nx = MD_ST_DIV;
                end
            end
            MD_ST_MUL:  state_nx = MD_ST_DONE;
            MD_ST_DIV:  if (cnt == CNT_W'(1)) state_nx = MD_ST_FIX;
            MD_ST_FIX:  state_nx = MD_ST_DONE;
            MD_ST_DONE: if (out_ready) state_nx = MD_ST_IDLE;
            default:    state_nx = MD_ST_IDLE;
        endcase
        if (flush) state_nx = MD_ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q   <= MD_K_MUL;
            mul_a    <= '0;
            mul_b    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else if (!flush) begin
            case (state)
                MD_ST_IDLE: begin
                    if (accept) begin
                        kind_q <= kind_in;
                        if (is_mul_in) begin
                            mul_a <= {(kind_in != MD_K_MULHU) && rs1[XLEN-1], rs1};
                            mul_b <= {(kind_in inside {MD_K_MUL, MD_K_MULH}) && rs2[XLEN-1], rs2};
                        end else begin
                            rem_q  <= '0;
                            quo_q  <= rs1_neg ? -rs1 : rs1;
                            dvsr_q <= rs2_neg ? -rs2 : rs2;
                            neg_q  <= rs1_neg ^ rs2_neg;
                            neg_r  <= rs1_neg;
                            cnt    <= ITERS;
                            if (special)       result_q <= special_res;
                            else if (fuse_hit) result_q <= fuse_res;
                        end
                    end
                end
                MD_ST_MUL: begin
                    result_q <= (kind_q == MD_K_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                end
                MD_ST_DIV: begin
                    rem_q <= chain_rem[DIV_STEP];
                    quo_q <= {quo_q[XLEN-1-DIV_STEP:0], q_bits};
                    cnt   <= cnt - CNT_W'(1);
                end
                MD_ST_FIX: begin
                    result_q <= (kind_q inside {MD_K_REM, MD_K_REMU}) ? rem_fix : quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fb_muldiv_unit.sv
// Scoreboard bench for fb_muldiv_unit: a driver pushes reference-model results and
// latencies, a negedge monitor compares whatever the unit presents.
module tb_fb_muldiv_unit;

    localparam int XLEN     = 32;
    localparam int DIV_STEP = 1;
    localparam int ITERS    = XLEN / DIV_STEP;
`ifdef FB_MULDIV_REM_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  op;
    logic [31:0] rs1, rs2, result;

    fb_muldiv_unit #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          c0;
        int          kind;
    } exp_t;

    exp_t        scb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          seen = 1'b0;
    int          hold_cycles = 0;
    bit          rand_ready = 1'b0;
    bit          m_fuse_vld = 1'b0;
    bit          m_fuse_sgn = 1'b0;
    logic [31:0] m_fuse_a = '0;
    logic [31:0] m_fuse_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference results straight from the ISA definitions using wide arithmetic.
    function automatic logic [31:0] ref_model(input int k, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, p;
        logic [63:0]        u;
        bit                 ovf;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (k)
            0: begin p = sa * sbv; return p[31:0]; end
            1: begin p = sa * sbv; return p[63:32]; end
            2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
            3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sbv; return p[31:0];
            end
            5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sbv; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 400 && scb.size() != 0; i++) @(posedge clk);
        #1;
        if (scb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results still outstanding", scb.size());
            scb.delete();
            rst = 1'b1;
            #1 rst = 1'b0;
            m_fuse_vld = 1'b0;
        end
    endtask

    // Called one time unit after a posedge with the unit idle.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] extra, input bit use_exp, input logic [31:0] exp_res);
        exp_t       e;
        bit         sgn, spec;
        logic [7:0] sel;
        sgn  = (k == 4) || (k == 6);
        spec = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        e.res  = use_exp ? exp_res : ref_model(k, a, b);
        e.kind = k;
        if (k < 4) begin
            e.lat = 2;
            m_fuse_vld = 1'b0;
        end else if (spec) begin
            e.lat = 1;
        end else if (FUSE && m_fuse_vld && m_fuse_a == a && m_fuse_b == b && m_fuse_sgn == sgn) begin
            e.lat = 1;
        end else begin
            e.lat = ITERS + 2;
            m_fuse_vld = 1'b1;
            m_fuse_a   = a;
            m_fuse_b   = b;
            m_fuse_sgn = sgn;
        end
        e.c0 = cyc;
        sel = 8'h80 >> k;
        op       = sel | (extra & (sel - 8'd1));
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        scb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 8'd0;
        wait_drain();
    endtask

    // Consumer side: random back-pressure or an explicit hold window.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_cycles > 0) begin
                out_ready = 1'b0;
                hold_cycles--;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // Monitor: latency on first valid cycle, value and in_ready on every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (scb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: result %h with nothing outstanding", result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check($sformatf("latency_k%0d", scb[0].kind), 64'(cyc - scb[0].c0), 64'(scb[0].lat));
                    end
                    check($sformatf("result_k%0d", scb[0].kind), {32'd0, result}, {32'd0, scb[0].res});
                    check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                    if (out_ready && !flush) begin
                        void'(scb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, last_a, last_b;
        bit          saw_valid;
        int          k;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 8'd0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed values with constants taken from the ISA definitions.
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'h0000_0001);
        issue(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'hFFFF_FFFE);
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'h0000_0000);
        issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'hFFFF_FFFF);
        issue(4, 32'hFFFF_FFF9, 32'd2,         8'd0, 1'b1, 32'hFFFF_FFFD);
        issue(6, 32'hFFFF_FFF9, 32'd2,         8'd0, 1'b1, 32'hFFFF_FFFF);
        issue(5, 32'h0000_1234, 32'd0,         8'd0, 1'b1, 32'hFFFF_FFFF);
        issue(6, 32'h8000_0000, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'h0000_0000);
        issue(4, 32'h8000_0000, 32'hFFFF_FFFF, 8'd0, 1'b1, 32'h8000_0000);
        issue(7, 32'hDEAD_BEEF, 32'd0,         8'd0, 1'b1, 32'hDEAD_BEEF);
        issue(0, 32'd6, 32'd7, 8'h7F, 1'b1, 32'd42);

        // Result must stay put with out_ready low in DONE.
        hold_cycles = 8;
        issue(0, 32'h0001_0003, 32'h0000_0005, 8'd0, 1'b1, 32'h0005_000F);

        // Flush in the middle of a divide: no result, idle on the next cycle.
        op = 8'h08; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 8'd0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        m_fuse_vld = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_busy", {63'd0, busy}, 64'd0);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("flush_no_valid", {63'd0, saw_valid}, 64'd0);

        // Flush while idle wins over a simultaneous request.
        @(posedge clk);
        #1;
        op = 8'h08; rs1 = 32'd9; rs2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0; op = 8'd0;
        check("flush_idle_busy", {63'd0, busy}, 64'd0);

        // op==0 is ignored.
        op = 8'd0; rs1 = 32'd5; rs2 = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("zero_op_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset while the multiply is in flight.
        op = 8'h80; rs1 = 32'd11; rs2 = 32'd13; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 8'd0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_result", {32'd0, result}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        m_fuse_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Repeat-divide reuse (short latency only when the fused entry exists).
        issue(4, 32'd100, 32'd7, 8'd0, 1'b1, 32'd14);
        issue(6, 32'd100, 32'd7, 8'd0, 1'b1, 32'd2);
        issue(0, 32'd3, 32'd5, 8'd0, 1'b1, 32'd15);
        issue(6, 32'd100, 32'd7, 8'd0, 1'b1, 32'd2);

        // Randomized traffic with back-pressure, priority-encoded op vectors and reuse.
        rand_ready = 1'b1;
        last_a = 32'd1;
        last_b = 32'd1;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 7);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2, 3:    begin a = last_a; b = last_b; end
                default: ;
            endcase
            issue(k, a, b, 8'($urandom), 1'b0, 32'd0);
            last_a = a;
            last_b = b;
        end

        rand_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(scb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
